trig_ringbuffer: RTL and testbench

TRIG_RINGBUFFER -- requirements
Module: trig_ringbuffer

---
 rtl/trig_ringbuffer.sv | 166 ++++++++++++++++
 tb/tb_trig_ringbuffer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_ringbuffer.sv
// trig_ringbuffer: multichannel pre/post trigger capture ring buffer
// with a shared write pointer and channel-major valid/ready readout.
module trig_ringbuffer #(
    parameter  int ADDR_W = 10,
    parameter  int WIDTH  = 14,
    parameter  int NCHAN  = 4,
    parameter  int PRE    = 64,
    parameter  int POST   = 192,
    localparam int CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [NCHAN*WIDTH-1:0] din,
    input  logic                   arm,
    input  logic                   trig,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic [CW-1:0]          rd_chan,
    output logic                   rd_last,
    output logic [ADDR_W-1:0]      aout,
    output logic [1:0]             state,
    output logic                   trig_miss
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN   = PRE + POST;

    generate
        if (PRE < 1 || POST < 1 || LEN > DEPTH - 1) begin : g_bad_params
            $error("trig_ringbuffer: need PRE>=1, POST>=1, PRE+POST<=DEPTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_POST    = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_aout;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_off;
    logic [CW-1:0]       r_ch;
    logic                r_miss;
    logic                r_valid;
    logic                r_last;
    logic [WIDTH-1:0]    r_data;
    logic [CW-1:0]       r_rchan;
    logic [WIDTH-1:0]    r_mem [NCHAN][DEPTH];

    logic                w_wr;
    logic                w_full;
    logic                w_accept;
    logic                w_miss;
    logic                w_load;
    logic                w_end;
    logic                w_last_word;
    logic [ADDR_W-1:0]   w_rd_addr;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (arm) w_next = S_ARMED;
            S_ARMED:   if (w_accept)
                           w_next = (wr_en && POST == 1) ? S_READOUT : S_POST;
            S_POST:    if (wr_en && r_cnt == ADDR_W'(POST - 1))
                           w_next = S_READOUT;
            S_READOUT: if (w_end) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr        = wr_en && (r_state != S_READOUT);
        w_full      = (r_cnt == ADDR_W'(PRE));
        w_accept    = (r_state == S_ARMED) && trig && w_full;
        w_miss      = (r_state == S_ARMED) && trig && !w_full;
        // Refill the output register when empty or when its word leaves.
        w_load      = (r_state == S_READOUT) &&
                      (!r_valid || (rd_ready && !r_last));
        w_end       = (r_state == S_READOUT) && r_valid && rd_ready && r_last;
        w_last_word = (r_ch == CW'(NCHAN - 1)) && (r_off == ADDR_W'(LEN - 1));
        w_rd_addr   = r_start + r_off;
    end

    always_ff @(posedge sysclk) begin
        if (w_wr) begin
            for (int c = 0; c < NCHAN; c++)
                r_mem[c][r_aout] <= din[c*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_aout  <= '0;
            r_cnt   <= '0;
            r_start <= '0;
            r_miss  <= 1'b0;
        end else begin
            r_miss <= w_miss;
            if (w_wr) r_aout <= r_aout + 1'b1;
            unique case (r_state)
                S_IDLE: if (arm) r_cnt <= '0;
                S_ARMED: begin
                    // The trigger-cycle sample is the first post sample.
                    if (w_accept) begin
                        r_start <= r_aout - ADDR_W'(PRE);
                        r_cnt   <= wr_en ? ADDR_W'(1) : '0;
                    end else if (wr_en && !w_full) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_POST: if (wr_en) r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_off   <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_rchan <= '0;
        end else if (w_load) begin
            r_data  <= r_mem[r_ch][w_rd_addr];
            r_rchan <= r_ch;
            r_last  <= w_last_word;
            r_valid <= 1'b1;
            if (w_last_word) begin
                r_off <= '0;
                r_ch  <= '0;
            end else if (r_off == ADDR_W'(LEN - 1)) begin
                r_off <= '0;
                r_ch  <= r_ch + 1'b1;
            end else begin
                r_off <= r_off + 1'b1;
            end
        end else if (w_end) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign rd_valid  = r_valid;
    assign rd_data   = r_data;
    assign rd_chan   = r_rchan;
    assign rd_last   = r_last;
    assign aout      = r_aout;
    assign state     = r_state;
    assign trig_miss = r_miss;

endmodule

// File: tb/tb_trig_ringbuffer.sv
// tb_trig_ringbuffer: table vectors, directed corner sequences and random
// events checked against a sample-history model of the capture window.
module tb_trig_ringbuffer;

    localparam int ADDR_W = 4;
    localparam int WIDTH  = 14;
    localparam int NCHAN  = 2;
    localparam int PRE    = 2;
    localparam int POST   = 3;
    localparam int LEN    = PRE + POST;
    localparam int DEPTH  = 16;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_POST  = 2;
    localparam int S_RO    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic        arm = 1'b0;
    logic        trig = 1'b0;
    logic        rd_ready = 1'b0;
    logic [27:0] din = '0;
    logic        rd_valid;
    logic [13:0] rd_data;
    logic [0:0]  rd_chan;
    logic        rd_last;
    logic [3:0]  aout;
    logic [1:0]  state;
    logic        trig_miss;

    trig_ringbuffer #(
        .ADDR_W(ADDR_W), .WIDTH(WIDTH), .NCHAN(NCHAN),
        .PRE(PRE), .POST(POST)
    ) dut (
        .sysclk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din),
        .arm(arm), .trig(trig), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_chan(rd_chan),
        .rd_last(rd_last), .aout(aout), .state(state),
        .trig_miss(trig_miss)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        int d;
        int c;
        bit l;
    } word_t;

    int    m_state, m_aout, m_fill, m_post, m_tidx, m_wait;
    bit    m_miss;
    int    h0[$];
    int    h1[$];
    word_t exp_q[$];
    int    got_d[$];

    task automatic model_reset();
        m_state = S_IDLE; m_aout = 0; m_fill = 0; m_post = 0;
        m_tidx = 0; m_wait = 0; m_miss = 0;
        h0.delete(); h1.delete(); exp_q.delete();
    endtask

    // The window is the PRE samples before the trigger write plus POST after.
    task automatic enter_readout();
        word_t w;
        m_state = S_RO;
        m_wait = 0;
        exp_q.delete();
        for (int c = 0; c < NCHAN; c++) begin
            for (int i = 0; i < LEN; i++) begin
                w.d = (c == 0) ? h0[m_tidx - PRE + i] : h1[m_tidx - PRE + i];
                w.c = c;
                w.l = (c == NCHAN - 1) && (i == LEN - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic model_step(input bit xfer);
        bit    nxt_miss;
        int    idx;
        word_t w;
        nxt_miss = (m_state == S_ARMED) && trig && (m_fill < PRE);
        if (m_state == S_RO) begin
            if (xfer && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                if (w.l) m_state = S_IDLE;
            end
        end else begin
            idx = h0.size();
            if (wr_en) begin
                h0.push_back(int'(din[13:0]));
                h1.push_back(int'(din[27:14]));
                m_aout = (m_aout + 1) % DEPTH;
            end
            case (m_state)
                S_IDLE: if (arm) begin m_state = S_ARMED; m_fill = 0; end
                S_ARMED: begin
                    if (trig && m_fill == PRE) begin
                        m_tidx = idx;
                        m_post = POST - (wr_en ? 1 : 0);
                        m_state = S_POST;
                        if (m_post == 0) enter_readout();
                    end else if (wr_en && m_fill < PRE) begin
                        m_fill++;
                    end
                end
                S_POST: begin
                    if (wr_en) m_post--;
                    if (m_post == 0) enter_readout();
                end
                default: ;
            endcase
        end
        m_miss = nxt_miss;
    endtask

    task automatic check(input bit keep);
        chk("state", int'(state), m_state);
        chk("aout", int'(aout), m_aout);
        chk("trig_miss", int'(trig_miss), int'(m_miss));
        if (keep) chk("valid_kept", int'(rd_valid), 1);
        if (m_state != S_RO) begin
            chk("valid_outside_readout", int'(rd_valid), 0);
        end else if (!rd_valid) begin
            m_wait++;
            chk("first_word_latency_ok", int'(m_wait <= 2), 1);
        end
        if (rd_valid && m_state == S_RO) begin
            chk("word_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("rd_data", int'(rd_data), exp_q[0].d);
                chk("rd_chan", int'(rd_chan), exp_q[0].c);
                chk("rd_last", int'(rd_last), int'(exp_q[0].l));
            end
        end
    endtask

    task automatic tick();
        bit xfer, keep;
        xfer = rd_valid && rd_ready;
        keep = rd_valid && !(rd_ready && rd_last);
        if (xfer) got_d.push_back(int'(rd_data));
        model_step(xfer);
        @(posedge clk);
        #1;
        check(keep);
    endtask

    task automatic drive(input bit w, input bit a, input bit t,
                         input bit r, input int k);
        wr_en = w; arm = a; trig = t; rd_ready = r;
        din = {14'(100 + k), 14'(k)};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_aout", int'(aout), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_last", int'(rd_last), 0);
        chk("rst_rd_chan", int'(rd_chan), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_trig_miss", int'(trig_miss), 0);
        model_reset();
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input bit rand_rdy, input bit wr_hold);
        got_d.delete();
        for (int i = 0; i < 300 && m_state == S_RO; i++) begin
            rd_ready = rand_rdy ? 1'($urandom % 2) : 1'b1;
            wr_en = wr_hold ? 1'b1 : 1'($urandom % 2);
            arm = 1'($urandom % 2);
            trig = 1'($urandom % 2);
            din = 28'($urandom);
            tick();
        end
        chk("readout_finished", int'(m_state == S_RO), 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic check_words(input int base);
        chk("word_count", got_d.size(), NCHAN * LEN);
        for (int i = 0; i < got_d.size() && i < NCHAN * LEN; i++)
            chk("window_word", got_d[i], (i < LEN) ? base + i : 100 + base + i - LEN);
    endtask

    typedef struct {
        bit w, a, t, r;
        int k, st, ao;
        bit miss;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 1, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 1, 1, 0};
        tbl[2]  = '{1, 0, 0, 0, 1, 1, 2, 0};
        tbl[3]  = '{1, 0, 0, 0, 2, 1, 3, 0};
        tbl[4]  = '{1, 0, 0, 0, 3, 1, 4, 0};
        tbl[5]  = '{1, 0, 0, 0, 4, 1, 5, 0};
        tbl[6]  = '{1, 0, 1, 0, 5, 2, 6, 0};
        tbl[7]  = '{1, 0, 0, 0, 6, 2, 7, 0};
        tbl[8]  = '{1, 0, 0, 0, 7, 3, 8, 0};
        tbl[9]  = '{1, 0, 0, 0, 8, 3, 8, 0};
        tbl[10] = '{1, 0, 0, 0, 9, 3, 8, 0};

        #1;
        do_reset();

        // Basic capture with writes held high through readout.
        foreach (tbl[i]) begin
            drive(tbl[i].w, tbl[i].a, tbl[i].t, tbl[i].r, tbl[i].k);
            tick();
            chk("tbl_state", int'(state), tbl[i].st);
            chk("tbl_aout", int'(aout), tbl[i].ao);
            chk("tbl_miss", int'(trig_miss), int'(tbl[i].miss));
        end
        drain(0, 1);
        check_words(3);
        chk("aout_frozen", int'(aout), 8);
        chk("idle_after_readout", int'(state), S_IDLE);

        // Early trigger is missed, later one accepted.
        do_reset();
        drive(0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0); tick();
        chk("miss_pulse", int'(trig_miss), 1);
        chk("miss_stays_armed", int'(state), S_ARMED);
        drive(0, 0, 0, 0, 0); tick();
        chk("miss_one_cycle", int'(trig_miss), 0);
        drive(1, 0, 0, 0, 1); tick();
        drive(1, 0, 1, 0, 2); tick();
        chk("late_trig_accepted", int'(state), S_POST);
        drive(1, 0, 0, 0, 3); tick();
        drive(1, 0, 0, 0, 4); tick();
        drain(0, 0);
        check_words(0);

        // Window straddles the address wrap.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            drive(1, 0, 0, 0, k); tick();
        end
        chk("prefill_aout", int'(aout), 14);
        drive(0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 14); tick();
        drive(1, 0, 0, 0, 15); tick();
        drive(1, 0, 1, 0, 16); tick();
        drive(1, 0, 0, 0, 17); tick();
        drive(1, 0, 0, 0, 18); tick();
        drain(1, 0);
        check_words(14);

        // Reset mid-capture, then a clean capture.
        do_reset();
        drive(0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 1); tick();
        drive(1, 0, 1, 0, 2); tick();
        chk("in_post_before_reset", int'(state), S_POST);
        #2;
        do_reset();
        drive(0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 50); tick();
        drive(1, 0, 0, 0, 51); tick();
        drive(1, 0, 1, 0, 52); tick();
        drive(1, 0, 0, 0, 53); tick();
        drive(1, 0, 0, 0, 54); tick();
        drain(1, 1);
        check_words(50);

        // Random events with random backpressure.
        for (int ev = 0; ev < 8; ev++) begin
            int nfill;
            nfill = $urandom_range(0, 20);
            for (int i = 0; i < nfill; i++) begin
                wr_en = 1'($urandom % 2);
                arm = 1'b0;
                trig = 1'($urandom % 2);
                din = 28'($urandom);
                tick();
            end
            wr_en = 1'($urandom % 2); arm = 1'b1; trig = 1'b0;
            din = 28'($urandom);
            tick();
            for (int i = 0; i < 300 && m_state != S_RO; i++) begin
                wr_en = ($urandom % 4) != 0;
                trig = ($urandom % 4) == 0;
                arm = 1'($urandom % 2);
                din = 28'($urandom);
                tick();
            end
            chk("trigger_reached", m_state, S_RO);
            if (m_state == S_RO) drain(1, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
